tinker_fetch_unit: RTL and testbench

Decoupled instruction-fetch stage for the Tinker core: owns the fetch PC, issues in-order 32-bit fetch requests to instruction memory over a valid/ready port, and buffers returned words in a small queue. Decode drains the queue via a valid/ready handshake. Branch resolution in execute redirects the PC, which flushes the queue and discards stale in-flight responses. The block sits directly upstream of the IF/ID latch and replaces the bare PC register plus combinational fetch.

---
 rtl/tinker_fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 54 +++++
 rtl/tinker_fetch_unit.sv | 135 +++++++++++++
 tb/tb_tinker_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_fetch_pkg.sv
// Shared types and constants for the Tinker instruction-fetch stage.
package tinker_fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 64;
   localparam logic [ADDR_W-1:0] TINKER_RESET_PC = 64'h2000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc4;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_t;

   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched words; clear overrides push and pop in the same cycle.
module fetch_queue
   import tinker_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   clear,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_push = push && !clear;
   assign do_pop  = pop && !clear && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   // Storage needs no reset: the head is only observed while the queue is non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/tinker_fetch_unit.sv
// Decoupled fetch stage: PC ownership, credit-limited imem requests, response queue, redirect flush.
// Optional same-cycle response bypass to decode when TINKER_FETCH_BYPASS_EN is defined.
module tinker_fetch_unit
   import tinker_fetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = TINKER_RESET_PC
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [ADDR_W-1:0]      imem_req_addr,
   input  logic                   imem_resp_valid,
   input  logic [INSTR_W-1:0]     imem_resp_data,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   halt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_W-1:0]     out_instr,
   output logic [ADDR_W-1:0]      out_pc4,
   output logic [$clog2(DEPTH):0] queue_count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     outstanding_next;
   logic [CW-1:0]     drop_cnt;
   fetch_state_t      state;
   fetch_state_t      state_next;

   logic [CW:0]       credit_used;
   logic              req_fire;
   logic              resp_drop;
   logic              resp_keep;
   logic              q_push;
   logic              q_pop;
   logic              q_full;
   logic              q_empty;
   fetch_entry_t      q_head;
   fetch_entry_t      resp_entry;

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data (resp_entry),
      .pop       (q_pop),
      .clear     (redirect_valid),
      .head      (q_head),
      .count     (queue_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign imem_req_addr = fetch_pc;
   assign credit_used   = {1'b0, queue_count} + {1'b0, outstanding};
   assign req_fire      = imem_req_valid && imem_req_ready;
   assign resp_drop     = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
   assign resp_keep     = imem_resp_valid && !resp_drop;
   assign resp_entry    = '{instr: imem_resp_data, pc4: next_pc(resp_pc)};

   // Queue occupancy plus in-flight requests never exceeds DEPTH, so kept responses always fit.
   always_comb begin
      imem_req_valid = 1'b0;
      if (!reset && (state == FETCH_RUN) && !redirect_valid &&
          (credit_used < (CW+1)'(DEPTH)))
         imem_req_valid = 1'b1;
   end

   always_comb begin
      out_valid = !q_empty;
      out_instr = '0;
      out_pc4   = '0;
      q_push    = resp_keep;
      if (!q_empty) begin
         out_instr = q_head.instr;
         out_pc4   = q_head.pc4;
      end
`ifdef TINKER_FETCH_BYPASS_EN
      else if (resp_keep) begin
         out_valid = 1'b1;
         out_instr = resp_entry.instr;
         out_pc4   = resp_entry.pc4;
         q_push    = !out_ready;
      end
`endif
      q_pop = out_valid && out_ready && !q_empty && !redirect_valid;
   end

   always_comb begin
      outstanding_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop_cnt <= outstanding_next;
         end else begin
            if (req_fire)  fetch_pc <= next_pc(fetch_pc);
            if (resp_keep) resp_pc  <= next_pc(resp_pc);
            if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH_RUN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (redirect_valid)  state_next = FETCH_RUN;
      else if (halt)       state_next = FETCH_HALTED;
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
      !(q_push && q_full && !redirect_valid));

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed-vector bench for tinker_fetch_unit with an in-order 1-cycle instruction memory model.
module tb_tinker_fetch_unit;
   import tinker_fetch_pkg::*;

   localparam int unsigned DEPTH = 4;
`ifdef TINKER_FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   imem_req_valid;
   logic                   imem_req_ready;
   logic [ADDR_W-1:0]      imem_req_addr;
   logic                   imem_resp_valid;
   logic [INSTR_W-1:0]     imem_resp_data;
   logic                   redirect_valid;
   logic [ADDR_W-1:0]      redirect_pc;
   logic                   halt;
   logic                   out_valid;
   logic                   out_ready;
   logic [INSTR_W-1:0]     out_instr;
   logic [ADDR_W-1:0]      out_pc4;
   logic [$clog2(DEPTH):0] queue_count;

   always #5 clk = ~clk;

   tinker_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (64'h2000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .halt            (halt),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc4         (out_pc4),
      .queue_count     (queue_count)
   );

   int unsigned n_vec = 0;
   int unsigned n_miscmp = 0;
   logic [63:0] pend[$];
   logic        mem_hold = 1'b0;
   logic        last_fire = 1'b0;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return 32'hA500_0000 ^ a[31:0];
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_resp();
      if (!mem_hold && pend.size() != 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = word_at(pend[0]);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   endtask

   // One clock: memory sees accepted requests at the edge and answers in the following cycle.
   task automatic step();
      logic        fire;
      logic [63:0] a;
      #1;
      fire = imem_req_valid && imem_req_ready;
      a    = imem_req_addr;
      if (imem_resp_valid) void'(pend.pop_front());
      @(posedge clk);
      #1;
      if (fire) pend.push_back(a);
      last_fire = fire;
      drive_resp();
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      mem_hold       = 1'b0;
      pend.delete();
      drive_resp();
      #1;
      check_eq("rst_req_valid", imem_req_valid, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_instr", out_instr, 0);
      check_eq("rst_out_pc4", out_pc4, 0);
      check_eq("rst_queue_count", queue_count, 0);
      check_eq("rst_req_addr", imem_req_addr, 64'h2000);
      step();
      step();
      reset = 1'b0;
      #1;
      check_eq("first_req_valid", imem_req_valid, 1);
   endtask

   task automatic wait_valid(input string tag, input int unsigned limit);
      int unsigned n = 0;
      while (!out_valid && n < limit) begin
         step();
         n++;
      end
      if (!out_valid) check_eq({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned fires;
      int unsigned delivered;
      int unsigned reqv;
      int unsigned n;

      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;

      // Streaming with 1-cycle memory, decode always ready.
      do_reset();
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      step();
      check_eq("stream_first_latency", out_valid, BYP);
      wait_valid("stream", 4);
      for (int k = 0; k < 8; k++) begin
         check_eq("stream_valid", out_valid, 1);
         check_eq("stream_pc4", out_pc4, 64'h2004 + 64'(4 * k));
         check_eq("stream_instr", out_instr, word_at(64'h2000 + 64'(4 * k)));
         step();
      end

      // Backpressure: credits cap outstanding + queued at DEPTH.
      do_reset();
      imem_req_ready = 1'b1;
      fires = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         fires += int'(last_fire);
      end
      check_eq("bp_accepts", fires, 4);
      check_eq("bp_count_full", queue_count, 4);
      check_eq("bp_req_blocked", imem_req_valid, 0);
      check_eq("bp_head_pc4", out_pc4, 64'h2004);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("bp_count_after_pop", queue_count, 3);
      check_eq("bp_req_reenabled", imem_req_valid, 1);
      fires = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         fires += int'(last_fire);
      end
      check_eq("bp_one_more_accept", fires, 1);
      check_eq("bp_count_refull", queue_count, 4);
      check_eq("bp_head_after_pop", out_pc4, 64'h2008);

      // Redirect with three requests in flight.
      do_reset();
      mem_hold = 1'b1;
      drive_resp();
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      step();
      step();
      step();
      imem_req_ready = 1'b0;
      check_eq("rd3_fetch_pc", imem_req_addr, 64'h200C);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3000;
      #1;
      check_eq("rd3_req_gated", imem_req_valid, 0);
      step();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      mem_hold       = 1'b0;
      drive_resp();
      #1;
      check_eq("rd3_out_valid_t1", out_valid, 0);
      check_eq("rd3_req_valid_t1", imem_req_valid, 1);
      check_eq("rd3_req_addr_t1", imem_req_addr, 64'h3000);
      wait_valid("rd3", 12);
      check_eq("rd3_pc4", out_pc4, 64'h3004);
      check_eq("rd3_instr", out_instr, 64'(word_at(64'h3000)));

      // Redirect coinciding with a response and a pop.
      n = 0;
      step();
      while (!(out_valid && imem_resp_valid) && n < 10) begin
         step();
         n++;
      end
      check_eq("rdc_setup_resp", imem_resp_valid, 1);
      check_eq("rdc_setup_valid", out_valid, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h4000;
      step();
      redirect_valid = 1'b0;
      #1;
      check_eq("rdc_count_zero", queue_count, 0);
      check_eq("rdc_out_valid", out_valid, 0);
      wait_valid("rdc", 12);
      check_eq("rdc_pc4", out_pc4, 64'h4004);

      // Halt with two in flight, then redirect resumes fetch.
      do_reset();
      mem_hold = 1'b1;
      drive_resp();
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      step();
      step();
      halt           = 1'b1;
      imem_req_ready = 1'b0;
      step();
      halt           = 1'b0;
      imem_req_ready = 1'b1;
      mem_hold       = 1'b0;
      drive_resp();
      #1;
      check_eq("halt_req_off", imem_req_valid, 0);
      delivered = 0;
      reqv      = 0;
      for (int k = 0; k < 8; k++) begin
         delivered += int'(out_valid);
         reqv      += int'(imem_req_valid);
         step();
      end
      check_eq("halt_delivered", delivered, 2);
      check_eq("halt_req_stays_off", reqv, 0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h2100;
      step();
      redirect_valid = 1'b0;
      #1;
      check_eq("halt_resume_valid", imem_req_valid, 1);
      check_eq("halt_resume_addr", imem_req_addr, 64'h2100);
      wait_valid("halt_resume", 6);
      check_eq("halt_resume_pc4", out_pc4, 64'h2104);

      // imem_req_ready toggling 1,0,1.
      do_reset();
      mem_hold = 1'b1;
      drive_resp();
      imem_req_ready = 1'b1;
      step();
      check_eq("tog_pc_after_accept", imem_req_addr, 64'h2004);
      imem_req_ready = 1'b0;
      step();
      check_eq("tog_pc_held", imem_req_addr, 64'h2004);
      imem_req_ready = 1'b1;
      step();
      check_eq("tog_pc_after_accept2", imem_req_addr, 64'h2008);
      imem_req_ready = 1'b0;
      mem_hold       = 1'b0;
      drive_resp();
      #1;
      check_eq("tog_resp_cycle_valid", out_valid, BYP);
      check_eq("tog_resp_cycle_count", queue_count, 0);
      step();
      check_eq("tog_next_valid", out_valid, 1);
      check_eq("tog_next_pc4", out_pc4, 64'h2004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
